// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared constants and types for the cache/memory arbiter
package mem_pkg;

  localparam int ADDR_W_DEF  = 32;
  localparam int LINE_W_DEF  = 128;
  localparam int TIMEOUT_DEF = 255;

  // Wide enough for the largest legal TIMEOUT (1023)
  localparam int CNT_W = 10;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_I_BUSY = 2'd1;
  localparam logic [1:0] ST_D_BUSY = 2'd2;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_I    = 2'b01;
  localparam logic [1:0] GRANT_D    = 2'b10;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_sel_e;

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - two-way round-robin pick between I-cache and D-cache
module rr_pick2
  import mem_pkg::*;
(
  input  logic     req_i,
  input  logic     req_d,
  input  req_sel_e last_served,
  output logic     pick_i,
  output logic     pick_d
);

  // A lone requester wins; on conflict the side not served last wins
  always_comb begin
    pick_i = req_i;
    pick_d = req_d;
    if (req_i && req_d) begin
      pick_i = (last_served == REQ_D);
      pick_d = (last_served == REQ_I);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - I/D cache line arbiter onto a single memory port
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int LINE_W  = LINE_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_mem_r,
  input  logic [ADDR_W-1:0] i_mem_addr,
  output logic              i_mem_ready,
  output logic [LINE_W-1:0] i_mem_data,
  input  logic              d_mem_r,
  input  logic              d_mem_w,
  input  logic [ADDR_W-1:0] d_mem_addr,
  input  logic [LINE_W-1:0] d_mem_wdata,
  output logic              d_mem_ready,
  output logic [LINE_W-1:0] d_mem_data,
  output logic              mem_r,
  output logic              mem_w,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [LINE_W-1:0] mem_data,
  output logic [1:0]        grant,
  output logic              timeout_err
);

  // Counter value seen in the BUSY cycle where the wait limit is reached
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]        state_q, state_d;
  logic              mem_r_q, mem_r_d;
  logic              mem_w_q, mem_w_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  req_sel_e          last_q, last_d;
  logic              pick_i, pick_d;
  logic              busy, expire;

  rr_pick2 u_rr_pick2 (
    .req_i       (i_mem_r),
    .req_d       (d_mem_r | d_mem_w),
    .last_served (last_q),
    .pick_i      (pick_i),
    .pick_d      (pick_d)
  );

  // Owner decode, completion/abort pulses and next-state selection
  always_comb begin
    state_d = state_q;
    mem_r_d = mem_r_q;
    mem_w_d = mem_w_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    last_d  = last_q;

    busy   = (state_q == ST_I_BUSY) || (state_q == ST_D_BUSY);
    expire = busy && !mem_ready && (cnt_q == CNT_LAST);

    i_mem_ready = (state_q == ST_I_BUSY) && mem_ready;
    d_mem_ready = (state_q == ST_D_BUSY) && mem_ready;
    timeout_err = expire;

    case (state_q)
      ST_IDLE: begin
        // Requests are only looked at here; the grant edge latches everything
        if (pick_i) begin
          state_d = ST_I_BUSY;
          addr_d  = i_mem_addr;
          mem_r_d = 1'b1;
          mem_w_d = 1'b0;
          wdata_d = '0;
          cnt_d   = '0;
          last_d  = REQ_I;
        end else if (pick_d) begin
          state_d = ST_D_BUSY;
          addr_d  = d_mem_addr;
          mem_r_d = d_mem_r;
          mem_w_d = d_mem_w;
          wdata_d = d_mem_w ? d_mem_wdata : '0;
          cnt_d   = '0;
          last_d  = REQ_D;
        end
      end
      ST_I_BUSY, ST_D_BUSY: begin
        // mem_ready on the limit cycle still wins over the abort
        if (mem_ready || expire) begin
          state_d = ST_IDLE;
          mem_r_d = 1'b0;
          mem_w_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        mem_r_d = 1'b0;
        mem_w_d = 1'b0;
      end
    endcase
  end

  // State and latched memory request registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mem_r_q <= 1'b0;
      mem_w_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      last_q  <= REQ_D;
    end else begin
      state_q <= state_d;
      mem_r_q <= mem_r_d;
      mem_w_q <= mem_w_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  // Read line goes to both caches; each qualifies it with its own ready
  always_comb begin
    i_mem_data = mem_data;
    d_mem_data = mem_data;
    mem_r      = mem_r_q;
    mem_w      = mem_w_q;
    mem_addr   = addr_q;
    mem_wdata  = wdata_q;
    grant      = (state_q == ST_I_BUSY) ? GRANT_I :
                 (state_q == ST_D_BUSY) ? GRANT_D : GRANT_NONE;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter
module tb_mem_arbiter;
  import mem_pkg::*;

  localparam logic [2:0] K_I  = 3'b001;
  localparam logic [2:0] K_D  = 3'b010;
  localparam logic [2:0] K_TO = 3'b100;

  typedef struct {
    logic [2:0]   kind;
    logic [31:0]  addr;
    logic         r;
    logic         w;
    logic [127:0] wdata;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_mem_r;
  logic [31:0]  i_mem_addr;
  logic         i_mem_ready;
  logic [127:0] i_mem_data;
  logic         d_mem_r;
  logic         d_mem_w;
  logic [31:0]  d_mem_addr;
  logic [127:0] d_mem_wdata;
  logic         d_mem_ready;
  logic [127:0] d_mem_data;
  logic         mem_r;
  logic         mem_w;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic         mem_ready;
  logic [127:0] mem_data;
  logic [1:0]   grant;
  logic         timeout_err;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];
  exp_t ev;

  mem_arbiter #(.ADDR_W(32), .LINE_W(128), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .i_mem_r(i_mem_r), .i_mem_addr(i_mem_addr), .i_mem_ready(i_mem_ready), .i_mem_data(i_mem_data),
    .d_mem_r(d_mem_r), .d_mem_w(d_mem_w), .d_mem_addr(d_mem_addr), .d_mem_wdata(d_mem_wdata),
    .d_mem_ready(d_mem_ready), .d_mem_data(d_mem_data),
    .mem_r(mem_r), .mem_w(mem_w), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_data(mem_data), .grant(grant), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input string name, input logic [1:0] exp);
    int n = 0;
    while (grant == GRANT_NONE && n < 20) begin
      tick();
      n++;
    end
    check(name, 128'(grant), 128'(exp));
  endtask

  // Called in BUSY cycle 1; raises mem_ready in cycle lat, returns in the following IDLE cycle
  task automatic finish_busy(input int lat);
    repeat (lat - 1) tick();
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
  endtask

  // Monitor: every ready/abort pulse must match the next queued expectation
  always @(negedge clk) begin
    if (i_mem_ready || d_mem_ready || timeout_err) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_event: got %b, want none", {timeout_err, d_mem_ready, i_mem_ready});
      end else begin
        ev = sb.pop_front();
        check("event_kind", 128'({timeout_err, d_mem_ready, i_mem_ready}), 128'(ev.kind));
        check("event_addr", 128'(mem_addr), 128'(ev.addr));
        check("event_strobes", 128'({mem_r, mem_w}), 128'({ev.r, ev.w}));
        check("event_wdata", mem_wdata, ev.wdata);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; i_mem_r = 1'b0; i_mem_addr = '0; d_mem_r = 1'b0; d_mem_w = 1'b0;
    d_mem_addr = '0; d_mem_wdata = '0; mem_ready = 1'b0; mem_data = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
    tick(); tick();
    check("rst_grant", 128'(grant), 128'(GRANT_NONE));
    check("rst_strobes", 128'({mem_r, mem_w}), 128'(2'b00));
    check("rst_addr", 128'(mem_addr), 128'(0));
    check("rst_wdata", mem_wdata, 128'(0));
    check("rst_err", 128'(timeout_err), 128'(0));
    check("rst_readies", 128'({i_mem_ready, d_mem_ready}), 128'(2'b00));
    rst = 1'b0;
    tick();

    // I-only read, memory answers in the third BUSY cycle
    i_mem_r = 1'b1; i_mem_addr = 32'h0040_0010;
    sb.push_back('{K_I, 32'h0040_0010, 1'b1, 1'b0, 128'h0});
    wait_grant("t1_grant", GRANT_I);
    check("t1_strobes", 128'({mem_r, mem_w}), 128'(2'b10));
    check("t1_addr", 128'(mem_addr), 128'(32'h0040_0010));
    check("t1_data_route", i_mem_data, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677);
    finish_busy(3);
    i_mem_r = 1'b0;
    check("t1_idle_grant", 128'(grant), 128'(GRANT_NONE));
    check("t1_strobe_drop", 128'(mem_r), 128'(0));
    mem_ready = 1'b1;
    check("idle_ready_ignored", 128'({i_mem_ready, d_mem_ready}), 128'(2'b00));
    tick();
    mem_ready = 1'b0;
    check("idle_stays_idle", 128'(grant), 128'(GRANT_NONE));

    // Conflict out of reset: I, bubble, D (I re-requesting), bubble, I
    rst = 1'b1; tick(); rst = 1'b0;
    i_mem_r = 1'b1; i_mem_addr = 32'h0000_1000;
    d_mem_r = 1'b1; d_mem_addr = 32'h2000_0040;
    sb.push_back('{K_I, 32'h0000_1000, 1'b1, 1'b0, 128'h0});
    sb.push_back('{K_D, 32'h2000_0040, 1'b1, 1'b0, 128'h0});
    sb.push_back('{K_I, 32'h0000_1040, 1'b1, 1'b0, 128'h0});
    wait_grant("t2_first_is_i", GRANT_I);
    finish_busy(1);
    i_mem_addr = 32'h0000_1040;
    check("t2_bubble1", 128'(grant), 128'(GRANT_NONE));
    tick();
    check("t2_second_is_d", 128'(grant), 128'(GRANT_D));
    check("t2_d_addr", 128'(mem_addr), 128'(32'h2000_0040));
    check("t2_d_wdata_zero", mem_wdata, 128'h0);
    finish_busy(2);
    d_mem_r = 1'b0;
    check("t2_bubble2", 128'(grant), 128'(GRANT_NONE));
    tick();
    check("t2_third_is_i", 128'(grant), 128'(GRANT_I));
    check("t2_i_addr", 128'(mem_addr), 128'(32'h0000_1040));
    finish_busy(1);
    i_mem_r = 1'b0;

    // D write
    d_mem_w = 1'b1; d_mem_addr = 32'h1001_0000;
    d_mem_wdata = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
    sb.push_back('{K_D, 32'h1001_0000, 1'b0, 1'b1, 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF});
    wait_grant("t3_grant", GRANT_D);
    check("t3_strobes", 128'({mem_r, mem_w}), 128'(2'b01));
    check("t3_addr", 128'(mem_addr), 128'(32'h1001_0000));
    check("t3_wdata", mem_wdata, 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF);
    finish_busy(2);
    d_mem_w = 1'b0;
    check("t3_strobe_drop", 128'({mem_r, mem_w}), 128'(2'b00));

    // Timeout with TIMEOUT=4: abort in the 4th BUSY cycle
    i_mem_r = 1'b1; i_mem_addr = 32'h0040_0100;
    sb.push_back('{K_TO, 32'h0040_0100, 1'b1, 1'b0, 128'h0});
    wait_grant("t4_grant", GRANT_I);
    tick(); tick();
    check("t4_cycle3_no_err", 128'(timeout_err), 128'(0));
    tick();
    check("t4_cycle4_err", 128'(timeout_err), 128'(1));
    check("t4_no_ready", 128'(i_mem_ready), 128'(0));
    i_mem_r = 1'b0;
    tick();
    check("t4_idle_after", 128'(grant), 128'(GRANT_NONE));
    check("t4_err_one_cycle", 128'(timeout_err), 128'(0));

    // Pointer advanced on the abort, so D wins; mem_ready in 4th cycle is success
    i_mem_r = 1'b1; i_mem_addr = 32'h0040_0200;
    d_mem_r = 1'b1; d_mem_addr = 32'h3000_0000;
    sb.push_back('{K_D, 32'h3000_0000, 1'b1, 1'b0, 128'h0});
    sb.push_back('{K_I, 32'h0040_0200, 1'b1, 1'b0, 128'h0});
    wait_grant("t4b_d_after_timeout", GRANT_D);
    finish_busy(4);
    d_mem_r = 1'b0;
    check("t4b_no_err", 128'(timeout_err), 128'(0));
    tick();
    check("t4b_then_i", 128'(grant), 128'(GRANT_I));
    finish_busy(1);
    i_mem_r = 1'b0;

    // Requester changes during BUSY are ignored
    i_mem_r = 1'b1; i_mem_addr = 32'h0050_0000;
    sb.push_back('{K_I, 32'h0050_0000, 1'b1, 1'b0, 128'h0});
    wait_grant("t5_grant", GRANT_I);
    i_mem_addr = 32'h0060_0000; i_mem_r = 1'b0;
    tick();
    check("t5_addr_held", 128'(mem_addr), 128'(32'h0050_0000));
    check("t5_still_busy", 128'(grant), 128'(GRANT_I));
    finish_busy(1);
    check("t5_done", 128'(grant), 128'(GRANT_NONE));

    // Reset during D_BUSY abandons the transaction
    d_mem_r = 1'b1; d_mem_addr = 32'h4000_0000;
    wait_grant("t6_grant", GRANT_D);
    tick();
    rst = 1'b1; d_mem_r = 1'b0;
    tick();
    rst = 1'b0;
    check("t6_grant", 128'(grant), 128'(GRANT_NONE));
    check("t6_strobes", 128'({mem_r, mem_w}), 128'(2'b00));
    check("t6_addr", 128'(mem_addr), 128'(0));
    check("t6_wdata", mem_wdata, 128'(0));
    mem_ready = 1'b1;
    check("t6_late_ready", 128'({i_mem_ready, d_mem_ready, timeout_err}), 128'(3'b000));
    tick();
    mem_ready = 1'b0;
    tick();

    check("scoreboard_drained", 128'(sb.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, 32, address width of all ports.
REQ-002 Parameter: LINE_W, 128, refill/writeback line width.
REQ-003 Parameter: TIMEOUT, 255, maximum wait in cycles for mem_ready before abort; legal range 1..1023.
REQ-004 Ports: clk  in  1  single clock; all state changes on rising edge.
REQ-005 Ports: rst  in  1  synchronous, active-high reset.
REQ-006 Ports: i_mem_r  in  1  I-cache line read request, level, held until i_mem_ready.
REQ-007 Ports: i_mem_addr  in  ADDR_W  I-cache request address.
REQ-008 Ports: i_mem_ready  out  1  one-cycle completion pulse to I-cache.
REQ-009 Ports: d_mem_r  in  1  D-cache line read request, level, held until d_mem_ready.
REQ-010 Ports: d_mem_w  in  1  D-cache line write request, level; d_mem_r and d_mem_w are never both 1.
REQ-011 Ports: d_mem_addr  in  ADDR_W  D-cache request address.
REQ-012 Ports: d_mem_wdata  in  LINE_W  D-cache writeback line.
REQ-013 Ports: d_mem_ready  out  1  one-cycle completion pulse to D-cache.
REQ-014 Ports: mem_r / mem_w  out  1 each  registered memory read/write strobes.
REQ-015 Ports: mem_addr  out  ADDR_W, mem_wdata  out  LINE_W  registered, latched at grant.
REQ-016 Ports: mem_ready  in  1, mem_data  in  LINE_W  memory completion pulse and read line.
REQ-017 Ports: mem_data is routed combinationally to both caches, unqualified; each cache qualifies it with its own ready pulse.
REQ-018 Ports: grant  out  2  one-hot owner: 01 = I-cache, 10 = D-cache, 00 = idle.
REQ-019 Ports: timeout_err  out  1  one-cycle pulse on abort.

Function
REQ-020 States: IDLE, I_BUSY, D_BUSY.
REQ-021 In IDLE with exactly one requester active, the FSM moves to that requester's BUSY state on the next edge.
REQ-022 In IDLE with both requesters active, grant goes round-robin: the requester not served last wins; the last-served pointer resets to D, so I-cache wins the first conflict.
REQ-023 On the grant edge the block latches mem_addr, mem_w, mem_wdata (D write only, else 0) and asserts mem_r or mem_w; the strobe is held high for the whole BUSY state.
REQ-024 In a BUSY state, mem_ready=1 makes the owner's ready output 1 combinationally in the same cycle; the next state is IDLE and strobes drop on that edge.
REQ-025 A completed transaction leaves at least one IDLE cycle before the next grant (one-cycle bubble), including when the same requester re-requests immediately.
REQ-026 mem_ready in IDLE is ignored: no ready pulse to either cache.
REQ-027 Requester inputs are sampled only in IDLE; changes during BUSY (address, data, or request deassert) do not affect the transaction in flight, and no abort is issued.
REQ-028 Wait counter: cleared on grant, incremented each BUSY cycle without mem_ready.
REQ-029 When the counter reaches TIMEOUT without mem_ready, the FSM goes to IDLE, pulses timeout_err for one cycle and gives no ready pulse; the last-served pointer still advances.
REQ-030 mem_ready in the same cycle the counter reaches TIMEOUT counts as success; timeout_err stays 0.
REQ-031 grant reflects the registered state: 01 in I_BUSY, 10 in D_BUSY, 00 in IDLE.

Reset
REQ-032 On rst: state = IDLE, grant = 00, mem_r = mem_w = 0, mem_addr = 0, mem_wdata = 0, counter = 0, timeout_err = 0, last-served = D.
REQ-033 rst during BUSY abandons the transaction without a ready pulse; a mem_ready arriving after reset is ignored per REQ-026.

Structure
REQ-034 State encoding, grant encodings and the TIMEOUT default go in a shared package (mem_pkg) with the other cache/memory constants.
REQ-035 Flat implementation; one optional sub-module, rr_pick2, for the two-way round-robin decision.

Verification
REQ-036 I-only: i_mem_r=1, addr=0x00400010; memory returns ready 3 cycles after grant -> grant=01, mem_r=1, mem_addr=0x00400010, then i_mem_ready pulses once and d_mem_ready stays 0.
REQ-037 Conflict: both requests active out of reset -> I served first, then after one bubble cycle D is served; repeating the conflict serves D first.
REQ-038 D write: d_mem_w=1, wdata=128'hDEAD...BEEF, addr=0x10010000 -> mem_w=1 with matching mem_wdata/mem_addr, mem_r=0, then a single d_mem_ready pulse.
REQ-039 Timeout: TIMEOUT=4, mem_ready never arrives -> timeout_err pulses in the 4th BUSY cycle, no ready pulse, FSM in IDLE next cycle; same test with mem_ready in the 4th cycle -> success, no error.
REQ-040 Mid-op changes: change i_mem_addr and drop i_mem_r during I_BUSY -> mem_addr unchanged and i_mem_ready still pulses; assert rst during D_BUSY -> all outputs at reset values next cycle and a late mem_ready is ignored.
